// File: rtl/rv32_wb_pkg.sv
// Shared types and encodings for the register-file write-back path.
package rv32_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  // live drops on pop or when a younger pipe write to the same rd kills the entry
  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } lu_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: selects the addressed byte/half of a raw load
// word and sign- or zero-extends it; non-load data passes through.
module wb_load_align
  import rv32_wb_pkg::*;
(
  input  logic [XLEN-1:0] i_data,
  input  logic            i_is_load,
  input  logic [1:0]      i_ld_size,
  input  logic            i_ld_uns,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Half selection uses only addr_lo[1]; size 11 falls through to word.
  always_comb begin
    w_byte = i_data[{i_addr_lo, 3'b000} +: 8];
    w_half = i_data[{i_addr_lo[1], 4'b0000} +: 16];
    o_data = i_data;
    if (i_is_load) begin
      case (i_ld_size)
        LD_BYTE: o_data = {{24{~i_ld_uns & w_byte[7]}}, w_byte};
        LD_HALF: o_data = {{16{~i_ld_uns & w_half[15]}}, w_half};
        default: o_data = i_data;
      endcase
    end else begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole driver of the register-file write port: merges the non-stallable MEM/WB
// result with a queued long-latency unit result stream, with kill and anti-starvation.
module regfile_write_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_data,
  input  logic              pipe_is_load,
  input  logic [1:0]        pipe_ld_size,
  input  logic              pipe_ld_uns,
  input  logic [1:0]        pipe_addr_lo,
  output logic              pipe_stall,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [31:0]       pend_mask
);

  localparam int PTR_W = $clog2(LU_DEPTH);
  localparam int CNT_W = $clog2(LU_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LU_DEPTH);
  localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_MAX - 1);

  lu_entry_t         r_q [LU_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;
  logic              r_stall;
  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_waddr;
  logic [XLEN-1:0]   r_rf_wdata;

  logic [XLEN-1:0]   w_pipe_aligned;
  logic              w_empty, w_full, w_push, w_pop, w_pipe_wr, w_head_wr;
  lu_entry_t         w_head;
  logic [STV_W-1:0]  w_starve_next;
  logic [31:0]       w_pend;

  wb_load_align u_align (
    .i_data    (pipe_data),
    .i_is_load (pipe_is_load),
    .i_ld_size (pipe_ld_size),
    .i_ld_uns  (pipe_ld_uns),
    .i_addr_lo (pipe_addr_lo),
    .o_data    (w_pipe_aligned)
  );

  // Slot selection: a stall cycle forces the head out; otherwise the pipe wins.
  always_comb begin
    w_empty   = (r_count == {CNT_W{1'b0}});
    w_full    = (r_count == DEPTH_C);
    w_push    = lu_valid && !w_full;
    w_pipe_wr = !r_stall && pipe_valid && (pipe_rd != 5'd0);
    w_pop     = !w_empty && !w_pipe_wr;
    w_head    = r_q[r_rptr];
    w_head_wr = w_pop && w_head.live && (w_head.rd != 5'd0);
    if (w_pop) begin
      w_starve_next = {STV_W{1'b0}};
    end else if (!w_empty) begin
      w_starve_next = r_starve + 1'b1;
    end else begin
      w_starve_next = {STV_W{1'b0}};
    end
  end

  // Queue storage, pointers, occupancy and kill of matching live entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LU_DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < LU_DEPTH; i++) begin
        if (w_pipe_wr && (r_q[i].rd == pipe_rd)) begin
          r_q[i].live <= 1'b0;
        end
      end
      if (w_pop) begin
        r_q[r_rptr].live <= 1'b0;
        r_rptr           <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_q[r_wptr].live <= !(w_pipe_wr && (lu_rd == pipe_rd));
        r_q[r_wptr].rd   <= lu_rd;
        r_q[r_wptr].data <= lu_data;
        r_wptr           <= r_wptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter and one-cycle stall pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= {STV_W{1'b0}};
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      r_stall  <= (w_starve_next == STV_LAST);
    end
  end

  // Registered write port; address and data are zeroed when no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
    end else if (w_pipe_wr) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= pipe_rd;
      r_rf_wdata <= w_pipe_aligned;
    end else if (w_head_wr) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_head.rd;
      r_rf_wdata <= w_head.data;
    end else begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
    end
  end

  // Pending mask from registered live bits; x0 never reported.
  always_comb begin
    w_pend = 32'd0;
    for (int i = 0; i < LU_DEPTH; i++) begin
      if (r_q[i].live) begin
        w_pend[r_q[i].rd] = 1'b1;
      end else begin
        w_pend = w_pend;
      end
    end
    w_pend[0] = 1'b0;
  end

  assign pend_mask  = w_pend;
  assign lu_ready   = !w_full;
  assign pipe_stall = r_stall;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: load-align vector table, directed multi-cycle sequences
// and randomized traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_is_load, pipe_ld_uns, lu_valid;
  logic [4:0]  pipe_rd, lu_rd;
  logic [31:0] pipe_data, lu_data;
  logic [1:0]  pipe_ld_size, pipe_addr_lo;
  logic        pipe_stall, lu_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pend_mask;

  regfile_write_arbiter #(.LU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_is_load(pipe_is_load), .pipe_ld_size(pipe_ld_size),
    .pipe_ld_uns(pipe_ld_uns), .pipe_addr_lo(pipe_addr_lo),
    .pipe_stall(pipe_stall), .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_rd(lu_rd), .lu_data(lu_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic live;
    logic [4:0] rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_wait;
  bit          m_stall;
  logic        e_we;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;

  typedef struct {
    logic        pv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ld;
    logic [1:0]  sz;
    logic        uns;
    logic [1:0]  al;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] d, input logic ld,
                                            input logic [1:0] sz, input logic uns,
                                            input logic [1:0] al);
    logic [31:0] v;
    if (!ld || sz[1]) return d;
    if (sz == 2'b00) begin
      v = (d >> (int'(al) * 8)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (d >> (int'(al[1]) * 16)) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_mask();
    logic [31:0] m = 32'd0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  // One clock: predict from current inputs and model state, clock, compare.
  task automatic step();
    bit stall, pwr, pop, push, nonempty;
    if (reset) begin
      mq.delete();
      m_wait = 0; m_stall = 0;
      e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
    end else begin
      stall    = m_stall;
      pwr      = !stall && pipe_valid && pipe_rd != 5'd0;
      nonempty = mq.size() != 0;
      pop      = nonempty && !pwr;
      push     = lu_valid && mq.size() < DEPTH;
      e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
      if (pwr) begin
        e_we = 1'b1; e_wa = pipe_rd;
        e_wd = ref_align(pipe_data, pipe_is_load, pipe_ld_size, pipe_ld_uns, pipe_addr_lo);
      end else if (pop && mq[0].live && mq[0].rd != 5'd0) begin
        e_we = 1'b1; e_wa = mq[0].rd; e_wd = mq[0].data;
      end
      if (pwr) foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{live: !(pwr && lu_rd == pipe_rd), rd: lu_rd, data: lu_data});
      if (pop) m_wait = 0;
      else if (nonempty) m_wait = m_wait + 1;
      else m_wait = 0;
      m_stall = (m_wait == SMAX - 1);
    end
    @(posedge clk);
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_wa});
    chk("rf_wdata", rf_wdata, e_wd);
    chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, m_stall});
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, mq.size() < DEPTH});
    chk("pend_mask", pend_mask, ref_mask());
  endtask

  task automatic idle();
    reset = 1'b0; pipe_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    pipe_is_load = 1'b0; pipe_ld_size = 2'b00; pipe_ld_uns = 1'b0;
    pipe_addr_lo = 2'b00; lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
  endtask

  initial begin
    int k;
    int stall_cycles;
    vecs[0]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 5'd5,  32'h0000_1234};
    vecs[1]  = '{1'b1, 5'd6,  32'h80FF_7F01, 1'b1, 2'b00, 1'b0, 2'd2, 1'b1, 5'd6,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 5'd6,  32'h80FF_7F01, 1'b1, 2'b01, 1'b1, 2'd2, 1'b1, 5'd6,  32'h0000_80FF};
    vecs[3]  = '{1'b1, 5'd1,  32'h80FF_7F01, 1'b1, 2'b00, 1'b0, 2'd0, 1'b1, 5'd1,  32'h0000_0001};
    vecs[4]  = '{1'b1, 5'd2,  32'h80FF_7F01, 1'b1, 2'b00, 1'b0, 2'd3, 1'b1, 5'd2,  32'hFFFF_FF80};
    vecs[5]  = '{1'b1, 5'd3,  32'h80FF_7F01, 1'b1, 2'b00, 1'b1, 2'd3, 1'b1, 5'd3,  32'h0000_0080};
    vecs[6]  = '{1'b1, 5'd4,  32'h80FF_7F01, 1'b1, 2'b01, 1'b0, 2'd0, 1'b1, 5'd4,  32'h0000_7F01};
    vecs[7]  = '{1'b1, 5'd8,  32'h80FF_7F01, 1'b1, 2'b01, 1'b0, 2'd1, 1'b1, 5'd8,  32'h0000_7F01};
    vecs[8]  = '{1'b1, 5'd9,  32'h80FF_7F01, 1'b1, 2'b01, 1'b0, 2'd3, 1'b1, 5'd9,  32'hFFFF_80FF};
    vecs[9]  = '{1'b1, 5'd10, 32'h80FF_7F01, 1'b1, 2'b10, 1'b0, 2'd1, 1'b1, 5'd10, 32'h80FF_7F01};
    vecs[10] = '{1'b1, 5'd11, 32'h80FF_7F01, 1'b1, 2'b11, 1'b0, 2'd2, 1'b1, 5'd11, 32'h80FF_7F01};
    vecs[11] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0000_0000};
    vecs[12] = '{1'b1, 5'd31, 32'h80FF_7F01, 1'b1, 2'b00, 1'b1, 2'd1, 1'b1, 5'd31, 32'h0000_007F};

    idle();
    reset = 1'b1;
    step(); step();
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset pend", pend_mask, 32'd0);
    chk("reset ready", {31'd0, lu_ready}, 32'd1);
    idle();

    // Pipe results and load alignment, one cycle each from an empty queue.
    for (int i = 0; i < 13; i++) begin
      pipe_valid = vecs[i].pv; pipe_rd = vecs[i].rd; pipe_data = vecs[i].data;
      pipe_is_load = vecs[i].ld; pipe_ld_size = vecs[i].sz;
      pipe_ld_uns = vecs[i].uns; pipe_addr_lo = vecs[i].al;
      step();
      chk($sformatf("vec%0d we", i), {31'd0, rf_we}, {31'd0, vecs[i].ewe});
      chk($sformatf("vec%0d waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].ewa});
      chk($sformatf("vec%0d wdata", i), rf_wdata, vecs[i].ewd);
    end
    idle(); step();

    // T3: single LU result drains through the queue.
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_00A5;
    step();
    chk("T3 pend", pend_mask, 32'h0000_0080);
    chk("T3 no bypass", {31'd0, rf_we}, 32'd0);
    idle(); step();
    chk("T3 we", {31'd0, rf_we}, 32'd1);
    chk("T3 waddr", {27'd0, rf_waddr}, 32'd7);
    chk("T3 wdata", rf_wdata, 32'h0000_00A5);
    chk("T3 pend clr", pend_mask, 32'd0);

    // T4: younger pipe write kills the queued entry.
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_0999;
    step();
    idle(); pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h0000_0001;
    step();
    chk("T4 wdata", rf_wdata, 32'h0000_0001);
    chk("T4 pend", pend_mask, 32'd0);
    idle(); step();
    chk("T4 killed pop", {31'd0, rf_we}, 32'd0);

    // T5: fill the queue behind a busy pipe until starvation forces a stall.
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0000_0033;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h0000_00AA;
    step();
    lu_rd = 5'd11; lu_data = 32'h0000_00BB;
    step();
    chk("T5 full ready", {31'd0, lu_ready}, 32'd0);
    lu_valid = 1'b0;
    k = 2;
    while (!pipe_stall && k < 20) begin
      step();
      k++;
    end
    chk("T5 stall after", k, SMAX);
    stall_cycles = 0;
    step();
    chk("T5 head we", {31'd0, rf_we}, 32'd1);
    chk("T5 head waddr", {27'd0, rf_waddr}, 32'd10);
    chk("T5 head wdata", rf_wdata, 32'h0000_00AA);
    chk("T5 stall pulse", {31'd0, pipe_stall}, 32'd0);
    idle(); step(); step();

    // T6: x0 pipe write dropped, then reset discards a queued entry.
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD_0000;
    lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'h0000_0012;
    step();
    chk("T6 x0 drop", {31'd0, rf_we}, 32'd0);
    chk("T6 pend", pend_mask, 32'h0000_1000);
    idle(); reset = 1'b1;
    step();
    chk("T6 rst pend", pend_mask, 32'd0);
    chk("T6 rst ready", {31'd0, lu_ready}, 32'd1);
    chk("T6 rst waddr", {27'd0, rf_waddr}, 32'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("T6 no stale", {31'd0, rf_we}, 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(199, 0) == 0);
      pipe_valid   = $urandom_range(1, 0);
      pipe_rd      = 5'($urandom_range(7, 0));
      pipe_data    = $urandom;
      pipe_is_load = $urandom_range(1, 0);
      pipe_ld_size = 2'($urandom_range(3, 0));
      pipe_ld_uns  = $urandom_range(1, 0);
      pipe_addr_lo = 2'($urandom_range(3, 0));
      lu_valid     = ($urandom_range(9, 0) < 4);
      lu_rd        = 5'($urandom_range(7, 0));
      lu_data      = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
